// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory pipeline stages, the arbiter and the shared
// single-port memory. The arbiter uses the slave view; the environment uses master.
interface mem_port_arbiter_if;
    logic        FetchReqF;
    logic [31:0] PCF;
    logic        FlushF;
    logic        DataReqM;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAdr;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [31:0] MemRData;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic [31:0] ReadDataM;
    logic        StallMemF;
    logic        StallMemM;

    modport slave (
        input  FetchReqF, PCF, FlushF, DataReqM, MemWriteM, DataAdrM, WriteDataM,
               MemReady, MemRData,
        output MemReq, MemWe, MemAdr, MemWData, InstrF, InstrValidF, ReadDataM,
               StallMemF, StallMemM
    );

    modport master (
        output FetchReqF, PCF, FlushF, DataReqM, MemWriteM, DataAdrM, WriteDataM,
               MemReady, MemRData,
        input  MemReq, MemWe, MemAdr, MemWData, InstrF, InstrValidF, ReadDataM,
               StallMemF, StallMemM
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one single-port memory.
// Data normally wins; a fetch that lost to a data access is granted next.
module mem_port_arbiter (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DATA, INSTR, DROP} state_t;

    state_t      state_q, state_d;
    logic        fetch_first_q, fetch_first_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        fetch_ok;

    assign fetch_ok = bus.FetchReqF & ~bus.FlushF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_first_q <= 1'b0;
            adr_q         <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_first_q <= fetch_first_d;
            adr_q         <= adr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_first_d = fetch_first_q;
        adr_d         = adr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        case (state_q)
            IDLE: begin
                if (fetch_first_q && fetch_ok) begin
                    state_d = INSTR;
                    adr_d   = bus.PCF;
                    wdata_d = '0;
                    we_d    = 1'b0;
                end else if (bus.DataReqM) begin
                    state_d = DATA;
                    adr_d   = bus.DataAdrM;
                    wdata_d = bus.WriteDataM;
                    we_d    = bus.MemWriteM;
                end else if (fetch_ok) begin
                    state_d = INSTR;
                    adr_d   = bus.PCF;
                    wdata_d = '0;
                    we_d    = 1'b0;
                end
            end
            DATA: begin
                if (bus.MemReady) begin
                    state_d = IDLE;
                    // A fetch that waited behind this access gets the next slot.
                    if (bus.FetchReqF) fetch_first_d = 1'b1;
                end
            end
            INSTR: begin
                if (bus.MemReady) begin
                    state_d       = IDLE;
                    fetch_first_d = 1'b0;
                end else if (bus.FlushF) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.MemReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory side is driven purely from registered state so it stays stable until MemReady.
    assign bus.MemReq   = (state_q != IDLE);
    assign bus.MemWe    = (state_q == DATA) & we_q;
    assign bus.MemAdr   = adr_q;
    assign bus.MemWData = wdata_q;

    assign bus.InstrValidF = (state_q == INSTR) & bus.MemReady & ~bus.FlushF;
    assign bus.InstrF      = bus.InstrValidF ? bus.MemRData : '0;
    assign bus.ReadDataM   = ((state_q == DATA) & bus.MemReady & ~we_q) ? bus.MemRData : '0;
    assign bus.StallMemM   = bus.DataReqM & ~((state_q == DATA) & bus.MemReady);
    assign bus.StallMemF   = bus.FetchReqF & ~bus.InstrValidF;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change just after each falling edge,
// outputs are checked 1 time unit later, state advances on the rising edge.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.FetchReqF  = 1'b0;
        bus.PCF        = '0;
        bus.FlushF     = 1'b0;
        bus.DataReqM   = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.DataAdrM   = '0;
        bus.WriteDataM = '0;
        bus.MemReady   = 1'b0;
        bus.MemRData   = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        bus.FetchReqF = 1'b1;
        bus.DataReqM  = 1'b1;
        bus.MemReady  = 1'b1;
        bus.MemRData  = 32'hCAFE0001;
        repeat (2) cyc();
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL rst_memreq got %b want 0", bus.MemReq); end
        n_cmp++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL rst_memwe got %b want 0", bus.MemWe); end
        n_cmp++; if (bus.MemAdr !== 32'h0) begin n_fail++; $display("FAIL rst_memadr got %h want 0", bus.MemAdr); end
        n_cmp++; if (bus.MemWData !== 32'h0) begin n_fail++; $display("FAIL rst_memwdata got %h want 0", bus.MemWData); end
        n_cmp++; if (bus.InstrValidF !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid got %b want 0", bus.InstrValidF); end
        n_cmp++; if (bus.InstrF !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", bus.InstrF); end
        n_cmp++; if (bus.ReadDataM !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus.ReadDataM); end
        n_cmp++; if (bus.StallMemF !== 1'b1) begin n_fail++; $display("FAIL rst_stallf got %b want 1", bus.StallMemF); end
        n_cmp++; if (bus.StallMemM !== 1'b1) begin n_fail++; $display("FAIL rst_stallm got %b want 1", bus.StallMemM); end
        idle_inputs();
        #1;
        n_cmp++; if (bus.StallMemF !== 1'b0) begin n_fail++; $display("FAIL rst_stallf_off got %b want 0", bus.StallMemF); end
        reset = 1'b1;
        cyc();
        // MemReady while idle must have no effect
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h0BADF00D;
        #1;
        n_cmp++; if (bus.ReadDataM !== 32'h0) begin n_fail++; $display("FAIL idle_ready_rdata got %h want 0", bus.ReadDataM); end
        n_cmp++; if (bus.InstrValidF !== 1'b0) begin n_fail++; $display("FAIL idle_ready_ivalid got %b want 0", bus.InstrValidF); end
        cyc();
        idle_inputs();
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL idle_ready_memreq got %b want 0", bus.MemReq); end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_fetch();
        cyc();
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h100;
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL fetch_c0_memreq got %b want 0", bus.MemReq); end
        n_cmp++; if (bus.StallMemF !== 1'b1) begin n_fail++; $display("FAIL fetch_c0_stallf got %b want 1", bus.StallMemF); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.PCF = 32'h104;
            #1;
            n_cmp++; if (bus.MemReq !== 1'b1) begin n_fail++; $display("FAIL fetch_wait%0d_memreq got %b want 1", i, bus.MemReq); end
            n_cmp++; if (bus.MemAdr !== 32'h100) begin n_fail++; $display("FAIL fetch_wait%0d_adr got %h want 100", i, bus.MemAdr); end
            n_cmp++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL fetch_wait%0d_we got %b want 0", i, bus.MemWe); end
            n_cmp++; if (bus.StallMemF !== 1'b1) begin n_fail++; $display("FAIL fetch_wait%0d_stallf got %b want 1", i, bus.StallMemF); end
        end
        cyc();
        bus.MemReady = 1'b1;
        bus.MemRData = 32'hE3A01005;
        #1;
        n_cmp++; if (bus.InstrValidF !== 1'b1) begin n_fail++; $display("FAIL fetch_ivalid got %b want 1", bus.InstrValidF); end
        n_cmp++; if (bus.InstrF !== 32'hE3A01005) begin n_fail++; $display("FAIL fetch_instr got %h want e3a01005", bus.InstrF); end
        n_cmp++; if (bus.StallMemF !== 1'b0) begin n_fail++; $display("FAIL fetch_stallf got %b want 0", bus.StallMemF); end
        n_cmp++; if (bus.ReadDataM !== 32'h0) begin n_fail++; $display("FAIL fetch_rdata got %h want 0", bus.ReadDataM); end
        cyc();
        idle_inputs();
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL fetch_done_memreq got %b want 0", bus.MemReq); end
        n_cmp++; if (bus.InstrValidF !== 1'b0) begin n_fail++; $display("FAIL fetch_done_ivalid got %b want 0", bus.InstrValidF); end
        $display("test_fetch done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_conflict();
        cyc();
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h300;
        bus.DataReqM  = 1'b1;
        bus.MemWriteM = 1'b0;
        bus.DataAdrM  = 32'h200;
        #1;
        n_cmp++; if (bus.StallMemM !== 1'b1) begin n_fail++; $display("FAIL conf_c0_stallm got %b want 1", bus.StallMemM); end
        cyc();
        #1;
        n_cmp++; if (bus.MemReq !== 1'b1) begin n_fail++; $display("FAIL conf_data_memreq got %b want 1", bus.MemReq); end
        n_cmp++; if (bus.MemAdr !== 32'h200) begin n_fail++; $display("FAIL conf_data_adr got %h want 200", bus.MemAdr); end
        n_cmp++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL conf_data_we got %b want 0", bus.MemWe); end
        cyc();
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h12345678;
        #1;
        n_cmp++; if (bus.ReadDataM !== 32'h12345678) begin n_fail++; $display("FAIL conf_rdata got %h want 12345678", bus.ReadDataM); end
        n_cmp++; if (bus.StallMemM !== 1'b0) begin n_fail++; $display("FAIL conf_stallm got %b want 0", bus.StallMemM); end
        n_cmp++; if (bus.StallMemF !== 1'b1) begin n_fail++; $display("FAIL conf_stallf got %b want 1", bus.StallMemF); end
        cyc();
        bus.MemReady = 1'b0;
        bus.DataAdrM = 32'h204;
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL conf_gap_memreq got %b want 0", bus.MemReq); end
        n_cmp++; if (bus.ReadDataM !== 32'h0) begin n_fail++; $display("FAIL conf_gap_rdata got %h want 0", bus.ReadDataM); end
        cyc();
        bus.MemReady = 1'b1;
        bus.MemRData = 32'hAAAA5555;
        #1;
        n_cmp++; if (bus.MemAdr !== 32'h300) begin n_fail++; $display("FAIL conf_fetchfirst_adr got %h want 300", bus.MemAdr); end
        n_cmp++; if (bus.InstrValidF !== 1'b1) begin n_fail++; $display("FAIL conf_fetch_ivalid got %b want 1", bus.InstrValidF); end
        n_cmp++; if (bus.InstrF !== 32'hAAAA5555) begin n_fail++; $display("FAIL conf_fetch_instr got %h want aaaa5555", bus.InstrF); end
        n_cmp++; if (bus.StallMemM !== 1'b1) begin n_fail++; $display("FAIL conf_fetch_stallm got %b want 1", bus.StallMemM); end
        cyc();
        bus.MemReady  = 1'b0;
        bus.FetchReqF = 1'b0;
        cyc();
        #1;
        n_cmp++; if (bus.MemAdr !== 32'h204) begin n_fail++; $display("FAIL conf_data2_adr got %h want 204", bus.MemAdr); end
        n_cmp++; if (bus.MemReq !== 1'b1) begin n_fail++; $display("FAIL conf_data2_memreq got %b want 1", bus.MemReq); end
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h00C0FFEE;
        #1;
        n_cmp++; if (bus.ReadDataM !== 32'h00C0FFEE) begin n_fail++; $display("FAIL conf_data2_rdata got %h want 00c0ffee", bus.ReadDataM); end
        cyc();
        idle_inputs();
        $display("test_conflict done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_store();
        cyc();
        bus.DataReqM   = 1'b1;
        bus.MemWriteM  = 1'b1;
        bus.DataAdrM   = 32'h40;
        bus.WriteDataM = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL store_c0_we got %b want 0", bus.MemWe); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.WriteDataM = 32'h0;
            bus.DataAdrM   = 32'h44;
            bus.MemWriteM  = 1'b0;
            #1;
            n_cmp++; if (bus.MemWe !== 1'b1) begin n_fail++; $display("FAIL store_wait%0d_we got %b want 1", i, bus.MemWe); end
            n_cmp++; if (bus.MemWData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_wait%0d_wdata got %h want deadbeef", i, bus.MemWData); end
            n_cmp++; if (bus.MemAdr !== 32'h40) begin n_fail++; $display("FAIL store_wait%0d_adr got %h want 40", i, bus.MemAdr); end
            n_cmp++; if (bus.StallMemM !== 1'b1) begin n_fail++; $display("FAIL store_wait%0d_stallm got %b want 1", i, bus.StallMemM); end
        end
        cyc();
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h55555555;
        #1;
        n_cmp++; if (bus.ReadDataM !== 32'h0) begin n_fail++; $display("FAIL store_rdata got %h want 0", bus.ReadDataM); end
        n_cmp++; if (bus.StallMemM !== 1'b0) begin n_fail++; $display("FAIL store_stallm got %b want 0", bus.StallMemM); end
        n_cmp++; if (bus.MemWe !== 1'b1) begin n_fail++; $display("FAIL store_ready_we got %b want 1", bus.MemWe); end
        cyc();
        idle_inputs();
        #1;
        n_cmp++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL store_done_we got %b want 0", bus.MemWe); end
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL store_done_memreq got %b want 0", bus.MemReq); end
        $display("test_store done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_flush_mid_fetch();
        cyc();
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h500;
        cyc();
        #1;
        n_cmp++; if (bus.MemAdr !== 32'h500) begin n_fail++; $display("FAIL flush_adr got %h want 500", bus.MemAdr); end
        cyc();
        bus.FlushF = 1'b1;
        bus.PCF    = 32'h600;
        #1;
        n_cmp++; if (bus.InstrValidF !== 1'b0) begin n_fail++; $display("FAIL flush_c_ivalid got %b want 0", bus.InstrValidF); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.FlushF = 1'b0;
            if (i == 2) begin
                bus.MemReady = 1'b1;
                bus.MemRData = 32'h00000BAD;
            end
            #1;
            n_cmp++; if (bus.MemReq !== 1'b1) begin n_fail++; $display("FAIL drop%0d_memreq got %b want 1", i, bus.MemReq); end
            n_cmp++; if (bus.MemAdr !== 32'h500) begin n_fail++; $display("FAIL drop%0d_adr got %h want 500", i, bus.MemAdr); end
            n_cmp++; if (bus.InstrValidF !== 1'b0) begin n_fail++; $display("FAIL drop%0d_ivalid got %b want 0", i, bus.InstrValidF); end
            n_cmp++; if (bus.StallMemF !== 1'b1) begin n_fail++; $display("FAIL drop%0d_stallf got %b want 1", i, bus.StallMemF); end
        end
        cyc();
        bus.MemReady = 1'b0;
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL drop_idle_memreq got %b want 0", bus.MemReq); end
        cyc();
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h11112222;
        #1;
        n_cmp++; if (bus.MemAdr !== 32'h600) begin n_fail++; $display("FAIL refetch_adr got %h want 600", bus.MemAdr); end
        n_cmp++; if (bus.InstrF !== 32'h11112222) begin n_fail++; $display("FAIL refetch_instr got %h want 11112222", bus.InstrF); end
        cyc();
        idle_inputs();
        $display("test_flush_mid_fetch done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_flush_and_ready();
        cyc();
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h700;
        cyc();
        bus.FlushF   = 1'b1;
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h99999999;
        #1;
        n_cmp++; if (bus.InstrValidF !== 1'b0) begin n_fail++; $display("FAIL fr_ivalid got %b want 0", bus.InstrValidF); end
        n_cmp++; if (bus.InstrF !== 32'h0) begin n_fail++; $display("FAIL fr_instr got %h want 0", bus.InstrF); end
        n_cmp++; if (bus.StallMemF !== 1'b1) begin n_fail++; $display("FAIL fr_stallf got %b want 1", bus.StallMemF); end
        cyc();
        idle_inputs();
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL fr_idle_memreq got %b want 0", bus.MemReq); end
        $display("test_flush_and_ready done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_reset_mid_data();
        cyc();
        bus.DataReqM = 1'b1;
        bus.DataAdrM = 32'h80;
        cyc();
        #1;
        n_cmp++; if (bus.MemReq !== 1'b1) begin n_fail++; $display("FAIL rmd_memreq_before got %b want 1", bus.MemReq); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL rmd_memreq_async got %b want 0", bus.MemReq); end
        n_cmp++; if (bus.MemAdr !== 32'h0) begin n_fail++; $display("FAIL rmd_adr_async got %h want 0", bus.MemAdr); end
        n_cmp++; if (bus.StallMemM !== 1'b1) begin n_fail++; $display("FAIL rmd_stallm got %b want 1", bus.StallMemM); end
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h77777777;
        #1;
        n_cmp++; if (bus.ReadDataM !== 32'h0) begin n_fail++; $display("FAIL rmd_rdata got %h want 0", bus.ReadDataM); end
        cyc();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL rmd_release_memreq got %b want 0", bus.MemReq); end
        cyc();
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h66666666;
        #1;
        n_cmp++; if (bus.ReadDataM !== 32'h0) begin n_fail++; $display("FAIL rmd_after_rdata got %h want 0", bus.ReadDataM); end
        cyc();
        idle_inputs();
        $display("test_reset_mid_data done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_flush_mid_fetch();
        test_flush_and_ready();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
